decode_stage: RTL
=================

Name: decode_stage

Overview:
- Pipelined, parametrised instruction-decode stage between fetch and execute in the scalar/vector core.
- Splits each instruction word into opcode, register indices and extended immediate, and raises flags for register-file type and operand usage.
- Flags illegal encodings and counts them.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so full throughput is kept under backpressure.
- Supports synchronous flush for branch redirect.

Parameters:
- REG_W, 5, register index width (scalar and vector files share it).
- IMM_W, 15, short immediate width.
- INST_W, 7+2*REG_W+IMM_W (=32), instruction width; derived, not overridable.
- DATA_W, 32, width of the extended immediate output; must be >= INST_W-7.
- SIGN_EXT, 1, 1 = sign-extend immediates, 0 = zero-extend.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  stage can accept a word.
- inst  in  INST_W  instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- opcode  out  7  inst[INST_W-1:INST_W-7].
- rd, rn, rm  out  REG_W each  register indices.
- imm  out  DATA_W  extended immediate.
- is_vec  out  1  operands address the vector file.
- use_rd, use_rn, use_rm, use_imm  out  1 each  field-valid flags.
- is_jump  out  1  long-immediate jump.
- illegal  out  1  illegal encoding.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal words.

Behaviour:

Field decode:
- Let cls = inst[W-1:W-2], v = inst[W-3], m = inst[W-4], with W = INST_W.
- rd = inst[W-8 -: REG_W], rn = the next REG_W bits, rm = top REG_W bits of the low IMM_W field, short imm = inst[IMM_W-1:0], long imm = inst[W-8:0].

Formats:
- cls 00, m=0: use_imm (short).
- cls 00, m=1: use_rd, use_rn, use_rm.
- cls 01: use_rd, use_rn, plus use_rm if m=0, else use_imm (short).
- cls 10 (load/store): use_rd, use_rn, use_imm (short).
- cls 11, m=0 (branch): use_rd, use_rn, use_imm (short).
- cls 11, m=1: is_jump, use_imm (long).
- is_vec = v for cls 00/01/10; is_vec = 0 for cls 11.
- cls 11 with v=1: illegal=1, every use_* flag = 0, is_jump = 0.

Output rules:
- Any field whose use_* flag is 0 is driven 0; no stale values are held.
- imm is extended to DATA_W per SIGN_EXT, and is 0 when use_imm=0.
- opcode is always passed through, including on illegal words.

Pipeline and skid buffer:
- Decode is combinational into a registered output stage (OUT) plus one skid register (SKID).
- Latency: word accepted in cycle N appears on out_valid/fields in cycle N+1.
- States:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: both valid.
- in_ready = !SKID.valid, driven purely from a register.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + !out_ready -> FULL, with the new word stored in SKID.
  - ONE + accept + out_ready -> ONE, with OUT replaced by the new word.
  - ONE + !accept + out_ready -> EMPTY.
  - FULL + out_ready -> ONE, with SKID moved to OUT. No accept is possible in FULL.
- Bundles leave in strict acceptance order.
- out_valid and all fields are held stable while out_valid && !out_ready.

Flush:
- Highest priority. In the cycle flush=1, both entries are invalidated at the next edge, and any word presented that cycle is discarded even if in_valid && in_ready.
- illegal_cnt is not changed by a flush, and a discarded word does not count.

Counter:
- illegal_cnt increments by 1 on each accepted word (in_valid && in_ready && !flush) that decodes illegal.
- It saturates at 2^CNT_W-1.

Reset:
- Asynchronous, active-low, may be asserted mid-operation.
- Reset forces state EMPTY, out_valid=0, in_ready=1, all fields/flags 0, illegal_cnt=0.
- In-flight words are lost.

Test Plan:
- Scalar short-immediate: inst=0x50327FFF, out_ready=1 -> next cycle out_valid=1, opcode=0x28, rd=3, rn=4, use_imm=1, use_rm=0, rm=0, imm=0xFFFFFFFF (SIGN_EXT=1); imm=0x00007FFF with SIGN_EXT=0.
- Jump: inst=0xD1000000 -> is_jump=1, use_rd=0, rd=0, imm=0xFF000000, is_vec=0.
- Illegal: inst=0xF0000000 accepted three times -> illegal=1 on each bundle, illegal_cnt=3. With CNT_W=2, five such words -> illegal_cnt saturates at 3.
- Backpressure: out_ready=0, present A, B, C back-to-back -> A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready -> A, B, C emerge in order with no drop or duplicate, and fields stay stable while stalled.
- Flush: in FULL with in_valid=1, assert flush one cycle -> next cycle out_valid=0, in_ready=1, presented word absent from the output, illegal_cnt unchanged.
- Reset mid-stream: deassert rst_n asynchronously while in FULL -> outputs 0, illegal_cnt=0 immediately. After release, the first accepted word appears with 1-cycle latency.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode stage between fetch and execute.
// Splits a word into opcode / register indices / extended immediate, flags
// operand usage and illegal encodings, and registers the bundle behind a
// valid/ready handshake with a 2-entry skid buffer (OUT + SKID).
module decode_stage #(
  parameter int REG_W    = 5,
  parameter int IMM_W    = 15,
  parameter int DATA_W   = 32,
  parameter int SIGN_EXT = 1,
  parameter int CNT_W    = 16,
  localparam int INST_W  = 7 + 2 * REG_W + IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        opcode,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rn,
  output logic [REG_W-1:0]  rm,
  output logic [DATA_W-1:0] imm,
  output logic              is_vec,
  output logic              use_rd,
  output logic              use_rn,
  output logic              use_rm,
  output logic              use_imm,
  output logic              is_jump,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  // Long (jump) immediate covers everything below the opcode.
  localparam int LONG_W = INST_W - 7;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rm;
    logic [DATA_W-1:0] imm;
    logic              is_vec;
    logic              use_rd;
    logic              use_rn;
    logic              use_rm;
    logic              use_imm;
    logic              is_jump;
    logic              illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // OUT and SKID invalid
    ONE   = 2'd1,  // OUT valid, SKID invalid
    FULL  = 2'd2   // OUT and SKID valid
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q;
  bundle_t           dec, out_q, skid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              load_out_in, load_skid, move_skid, clear_out;

  logic [1:0] cls;
  logic       v_bit, m_bit;

  assign cls   = inst[INST_W-1 -: 2];
  assign v_bit = inst[INST_W-3];
  assign m_bit = inst[INST_W-4];

  // Extend the low 'width' bits of val to DATA_W (sign or zero per SIGN_EXT).
  function automatic logic [DATA_W-1:0] extend(input logic [LONG_W-1:0] val,
                                               input int width);
    logic [DATA_W-1:0] z;
    logic [DATA_W-1:0] r;
    logic              s;
    z = DATA_W'(val);
    s = (SIGN_EXT != 0) ? z[width-1] : 1'b0;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = (i < width) ? z[i] : s;
    end
    return r;
  endfunction

  // Combinational decode of the presented word into a bundle.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    dec        = '0;
    dec.opcode = inst[INST_W-1 -: 7];
    unique case (cls)
      2'b00: begin
        dec.is_vec = v_bit;
        if (m_bit) begin
          dec.use_rd = 1'b1;
          dec.use_rn = 1'b1;
          dec.use_rm = 1'b1;
        end else begin
          dec.use_imm = 1'b1;
        end
      end
      2'b01: begin
        dec.is_vec  = v_bit;
        dec.use_rd  = 1'b1;
        dec.use_rn  = 1'b1;
        dec.use_rm  = !m_bit;
        dec.use_imm = m_bit;
      end
      2'b10: begin
        dec.is_vec  = v_bit;
        dec.use_rd  = 1'b1;
        dec.use_rn  = 1'b1;
        dec.use_imm = 1'b1;
      end
      default: begin
        // cls 11: v=1 is reserved; m selects branch vs long jump.
        if (v_bit) begin
          dec.illegal = 1'b1;
        end else if (m_bit) begin
          dec.is_jump = 1'b1;
          dec.use_imm = 1'b1;
        end else begin
          dec.use_rd  = 1'b1;
          dec.use_rn  = 1'b1;
          dec.use_imm = 1'b1;
        end
      end
    endcase
    // Unused fields are forced to zero so nothing stale leaks downstream.
    dec.rd = dec.use_rd ? inst[INST_W-8 -: REG_W]         : '0;
    dec.rn = dec.use_rn ? inst[INST_W-8-REG_W -: REG_W]   : '0;
    dec.rm = dec.use_rm ? inst[IMM_W-1 -: REG_W]          : '0;
    if (dec.use_imm) begin
      dec.imm = dec.is_jump ? extend(inst[LONG_W-1:0], LONG_W)
                            : extend(LONG_W'(inst[IMM_W-1:0]), IMM_W);
    end
  end

  assign accept = in_valid && ready_q && !flush;

  // Next-state and datapath-steering decisions for the skid buffer.
  always_comb begin
    state_d     = state_q;
    load_out_in = 1'b0;
    load_skid   = 1'b0;
    move_skid   = 1'b0;
    clear_out   = 1'b0;
    if (flush) begin
      state_d   = EMPTY;
      clear_out = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            load_out_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && out_ready) begin
            load_out_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_d   = EMPTY;
            clear_out = 1'b1;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_d   = ONE;
            move_skid = 1'b1;
          end
        end
        default: begin
          state_d   = EMPTY;
          clear_out = 1'b1;
        end
      endcase
    end
  end

  // State register; in_ready comes straight from its own flop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
    end
  end

  // OUT and SKID bundle registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: bundle registers are reset because their contents are visible on the outputs.
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (clear_out) begin
        out_q <= '0;
      end else if (load_out_in) begin
        out_q <= dec;
      end else if (move_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  // Saturating count of accepted illegal words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign opcode      = out_q.opcode;
  assign rd          = out_q.rd;
  assign rn          = out_q.rn;
  assign rm          = out_q.rm;
  assign imm         = out_q.imm;
  assign is_vec      = out_q.is_vec;
  assign use_rd      = out_q.use_rd;
  assign use_rn      = out_q.use_rn;
  assign use_rm      = out_q.use_rm;
  assign use_imm     = out_q.use_imm;
  assign is_jump     = out_q.is_jump;
  assign illegal     = out_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule
